// File: rtl/uart_baud_gen_frac.sv
// Fractional UART baud generator: produces oversample, mid-bit and bit ticks.
// New divisor/OSR settings wait in a shadow register until a bit boundary, or are taken at once while idle.
module uart_baud_gen_frac #(
  parameter int DIV_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int DEF_DIV  = 3,
  parameter int DEF_FRAC = 0,
  parameter int DEF_OSR  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              restart,
  input  logic              cfg_load,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic [1:0]        osr_sel,
  output logic              cfg_pending,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              bit_tick
);

  logic [DIV_W-1:0]  act_div, sh_div;
  logic [FRAC_W-1:0] act_frac, sh_frac;
  logic [1:0]        act_osr, sh_osr;

  logic [DIV_W-1:0]  cnt;
  logic [3:0]        os_cnt;
  logic [FRAC_W-1:0] acc;
  logic              cur_carry;

  logic [DIV_W-1:0]  div_m1;
  logic [FRAC_W:0]   sum;
  logic              carry_now;
  logic [DIV_W:0]    len_m1;
  logic              interval_end;
  logic [3:0]        osr_last, osr_mid;
  logic              bit_last;
  logic              bit_now;
  logic              apply;

  // The carry for an interval is decided on its first cycle and held for the rest of it.
  always_comb begin
    div_m1       = (act_div == '0) ? '0 : act_div - DIV_W'(1);
    sum          = {1'b0, acc} + {1'b0, act_frac};
    carry_now    = (cnt == '0) ? sum[FRAC_W] : cur_carry;
    len_m1       = {1'b0, div_m1} + {{DIV_W{1'b0}}, carry_now};
    interval_end = ({1'b0, cnt} == len_m1);
    case (act_osr)
      2'd1:    begin osr_last = 4'd7; osr_mid = 4'd3; end
      2'd2:    begin osr_last = 4'd3; osr_mid = 4'd1; end
      default: begin osr_last = 4'd15; osr_mid = 4'd7; end
    endcase
    bit_last = (os_cnt >= osr_last);
    bit_now  = en && interval_end && bit_last;
    apply    = cfg_pending && (bit_now || !en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_div     <= DIV_W'(DEF_DIV);
      act_frac    <= FRAC_W'(DEF_FRAC);
      act_osr     <= 2'(DEF_OSR);
      sh_div      <= DIV_W'(DEF_DIV);
      sh_frac     <= FRAC_W'(DEF_FRAC);
      sh_osr      <= 2'(DEF_OSR);
      cfg_pending <= 1'b0;
      cnt         <= '0;
      os_cnt      <= '0;
      acc         <= '0;
      cur_carry   <= 1'b0;
      os_tick     <= 1'b0;
      mid_tick    <= 1'b0;
      bit_tick    <= 1'b0;
    end else if (restart) begin
      cnt       <= '0;
      os_cnt    <= '0;
      acc       <= '0;
      cur_carry <= 1'b0;
      os_tick   <= 1'b0;
      mid_tick  <= 1'b0;
      bit_tick  <= 1'b0;
      if (cfg_load) begin
        act_div     <= div_int;
        act_frac    <= div_frac;
        act_osr     <= osr_sel;
        sh_div      <= div_int;
        sh_frac     <= div_frac;
        sh_osr      <= osr_sel;
        cfg_pending <= 1'b0;
      end else if (cfg_pending) begin
        act_div     <= sh_div;
        act_frac    <= sh_frac;
        act_osr     <= sh_osr;
        cfg_pending <= 1'b0;
      end
    end else begin
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
      if (en) begin
        if (cnt == '0) begin
          acc       <= sum[FRAC_W-1:0];
          cur_carry <= sum[FRAC_W];
        end
        if (interval_end) begin
          cnt      <= '0;
          os_tick  <= 1'b1;
          mid_tick <= (os_cnt == osr_mid);
          bit_tick <= bit_last;
          os_cnt   <= bit_last ? 4'd0 : os_cnt + 4'd1;
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end
      // Apply overrides the accumulator update so the new config starts with no carry.
      if (apply) begin
        act_div     <= sh_div;
        act_frac    <= sh_frac;
        act_osr     <= sh_osr;
        acc         <= '0;
        cfg_pending <= 1'b0;
      end
      if (cfg_load) begin
        sh_div      <= div_int;
        sh_frac     <= div_frac;
        sh_osr      <= osr_sel;
        cfg_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Scoreboard bench for uart_baud_gen_frac: expected ticks are queued per scenario
// with hand-computed cycle numbers, and a negedge monitor matches every DUT tick against them.
module tb_uart_baud_gen_frac;

  logic        clk = 1'b0;
  logic        rst, en, restart, cfg_load;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic [1:0]  osr_sel;
  logic        cfg_pending, os_tick, mid_tick, bit_tick;

  uart_baud_gen_frac dut (
    .clk(clk), .rst(rst), .en(en), .restart(restart), .cfg_load(cfg_load),
    .div_int(div_int), .div_frac(div_frac), .osr_sel(osr_sel),
    .cfg_pending(cfg_pending), .os_tick(os_tick), .mid_tick(mid_tick), .bit_tick(bit_tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {int c; bit m; bit b;} exp_t;
  exp_t q[$];
  exp_t e;
  int tests = 0;
  int fails = 0;
  int b;

  task automatic push(input int c, input bit m, input bit bt);
    exp_t x;
    x.c = c; x.m = m; x.b = bt;
    q.push_back(x);
  endtask

  task automatic at(input int n);
    wait (cyc >= n);
    #1;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cyc %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic load(input int d, input int f, input int o);
    cfg_load = 1'b1;
    div_int  = 16'(d);
    div_frac = 4'(f);
    osr_sel  = 2'(o);
  endtask

  // Monitor: retire overdue expectations, then match any tick seen this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].c < cyc) begin
      tests++; fails++;
      $display("FAIL missed_tick: expected os_tick at cyc %0d, still absent at cyc %0d", q[0].c, cyc);
      void'(q.pop_front());
    end
    if ((mid_tick || bit_tick) && !os_tick) begin
      tests++; fails++;
      $display("FAIL lone_strobe at cyc %0d: mid=%b bit=%b without os_tick", cyc, mid_tick, bit_tick);
    end
    if (os_tick) begin
      tests++;
      if (q.size() == 0 || q[0].c != cyc) begin
        fails++;
        $display("FAIL unexpected_tick at cyc %0d: next expected at %0d", cyc,
                 (q.size() > 0) ? q[0].c : -1);
      end else begin
        e = q.pop_front();
        if (e.m != mid_tick || e.b != bit_tick) begin
          fails++;
          $display("FAIL tick_flags at cyc %0d: mid=%b bit=%b, expected mid=%b bit=%b",
                   cyc, mid_tick, bit_tick, e.m, e.b);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; restart = 1'b0; cfg_load = 1'b0;
    div_int = '0; div_frac = '0; osr_sel = '0;

    // Default config from reset release: tick every 3, mid on 8th, bit on 16th.
    at(3);
    chk("rst_os_tick", os_tick, 1'b0);
    chk("rst_mid_tick", mid_tick, 1'b0);
    chk("rst_bit_tick", bit_tick, 1'b0);
    chk("rst_cfg_pending", cfg_pending, 1'b0);
    rst = 1'b0; en = 1'b1; b = cyc;
    for (int k = 1; k <= 16; k++) push(b + 3*k, k == 8, k == 16);
    at(b + 48); en = 1'b0;

    // Fractional 3.5 at 4x, loaded while idle: intervals 3,4,3,4.
    at(b + 50); load(3, 8, 2);
    at(b + 51); cfg_load = 1'b0;
    chk("idle_load_pending", cfg_pending, 1'b1);
    at(b + 52);
    chk("idle_apply_pending", cfg_pending, 1'b0);
    en = 1'b1; b = cyc;
    push(b + 3, 0, 0); push(b + 7, 1, 0); push(b + 10, 0, 0); push(b + 14, 0, 1);
    push(b + 17, 0, 0); push(b + 21, 1, 0); push(b + 24, 0, 0); push(b + 28, 0, 1);
    at(b + 28); en = 1'b0;

    // 16x running, switch to 8x mid-bit: pending until bit boundary, next bit 8 ticks.
    at(b + 30); load(3, 0, 0);
    at(b + 31); cfg_load = 1'b0;
    at(b + 32); en = 1'b1; b = cyc;
    for (int k = 1; k <= 16; k++) push(b + 3*k, k == 8, k == 16);
    for (int j = 1; j <= 8; j++) push(b + 48 + 3*j, j == 4, j == 8);
    at(b + 20); load(3, 0, 1);
    at(b + 21); cfg_load = 1'b0;
    chk("midbit_pending_set", cfg_pending, 1'b1);
    at(b + 47);
    chk("midbit_pending_hold", cfg_pending, 1'b1);
    at(b + 48);
    chk("midbit_pending_clr", cfg_pending, 1'b0);
    at(b + 72); en = 1'b0;

    // Restart at os_cnt=5, cnt=1.
    at(b + 74); load(3, 0, 0);
    at(b + 75); cfg_load = 1'b0;
    at(b + 76); en = 1'b1; b = cyc;
    for (int k = 1; k <= 5; k++) push(b + 3*k, 0, 0);
    at(b + 16); restart = 1'b1;
    at(b + 17); restart = 1'b0;
    chk("restart_os_tick", os_tick, 1'b0);
    chk("restart_bit_tick", bit_tick, 1'b0);
    for (int k = 1; k <= 16; k++) push(b + 17 + 3*k, k == 8, k == 16);
    at(b + 65); en = 1'b0;

    // Enable dropped 10 cycles mid-interval at div 5, 4x.
    at(b + 67); load(5, 0, 2);
    at(b + 68); cfg_load = 1'b0;
    at(b + 69); en = 1'b1; b = cyc;
    push(b + 5, 0, 0); push(b + 20, 1, 0); push(b + 25, 0, 0); push(b + 30, 0, 1);
    at(b + 7); en = 1'b0;
    at(b + 17); en = 1'b1;
    at(b + 30); en = 1'b0;

    // div_int = 0 behaves as 1: tick every cycle.
    at(b + 32); load(0, 0, 2);
    at(b + 33); cfg_load = 1'b0;
    at(b + 34); en = 1'b1; b = cyc;
    for (int k = 1; k <= 8; k++) push(b + k, (k % 4) == 2, (k % 4) == 0);
    at(b + 8); en = 1'b0;

    // Reset with a pending config: pending lost, defaults active.
    at(b + 10); load(5, 0, 2);
    at(b + 11); cfg_load = 1'b0;
    at(b + 12); en = 1'b1; b = cyc;
    at(b + 2); load(7, 3, 1);
    at(b + 3); cfg_load = 1'b0;
    chk("pre_rst_pending", cfg_pending, 1'b1);
    rst = 1'b1; en = 1'b0;
    at(b + 4);
    chk("post_rst_pending", cfg_pending, 1'b0);
    chk("post_rst_os_tick", os_tick, 1'b0);
    chk("post_rst_mid_tick", mid_tick, 1'b0);
    chk("post_rst_bit_tick", bit_tick, 1'b0);
    rst = 1'b0; en = 1'b1; b = cyc;
    for (int k = 1; k <= 16; k++) push(b + 3*k, k == 8, k == 16);
    at(b + 48); en = 1'b0;
    at(b + 52);

    while (q.size() > 0) begin
      tests++; fails++;
      $display("FAIL never_seen: expected os_tick at cyc %0d not observed", q[0].c);
      void'(q.pop_front());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_baud_gen_frac.md
Name: uart_baud_gen_frac

Overview:
- Runtime-programmable UART baud generator with a fractional divisor and selectable oversampling ratio (4/8/16).
- Produces three outputs:
  - an oversample tick for the RX sampler,
  - a mid-bit sample strobe,
  - a bit-rate tick for the TX shifter.
- Shared by uart_tx/uart_rx. A restart input lets RX realign bit phase on start-bit detection.
- New divisor/OSR values load through a shadow register and are applied glitch-free on a bit boundary.

Parameters:
- DIV_W, 16, width of integer divisor (clk cycles per oversample tick).
- FRAC_W, 4, width of fractional divisor; fraction = div_frac / 2^FRAC_W.
- DEF_DIV, 3, integer divisor after reset.
- DEF_FRAC, 0, fractional divisor after reset.
- DEF_OSR, 0, osr_sel after reset.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  count enable; 0 freezes all counters
- restart  in  1  one-cycle pulse: realign phase, apply pending config
- cfg_load  in  1  one-cycle pulse: capture div_int/div_frac/osr_sel into shadow
- div_int  in  DIV_W  integer divisor; 0 treated as 1
- div_frac  in  FRAC_W  fractional divisor
- osr_sel  in  2  0:16x, 1:8x, 2:4x, 3:16x (reserved, decodes as 16)
- cfg_pending  out  1  shadow holds config not yet applied
- os_tick  out  1  oversample tick, one cycle
- mid_tick  out  1  mid-bit strobe, coincident with os_tick
- bit_tick  out  1  bit-period tick, coincident with os_tick

Behaviour:
- All outputs registered.
- Reset state:
  - All outputs 0.
  - Internal counters cnt, os_cnt and frac accumulator acc are 0.
  - Active and shadow config = DEF_DIV/DEF_FRAC/DEF_OSR.
- Priority: rst > restart > en.
- Interval length: at the start of each os interval, {carry, acc_next} = acc + frac_active.
  - Interval length L = max(div_int_active, 1) + carry.
  - acc <= acc_next.
  - The first interval after reset, restart or config apply has acc = 0, so carry = 0.
- Counting: cnt counts 0..L-1 while en = 1.
  - On the edge where cnt == L-1: os_tick <= 1, cnt <= 0; otherwise os_tick <= 0.
  - Example: en = 1 from reset release, div = D, frac = 0 → os_tick high after edges D, 2D, 3D, …
- os_cnt advances on each os_tick, wrapping at OSR−1 (OSR = 16/8/4).
  - bit_tick <= 1 on the os_tick where os_cnt == OSR−1.
  - mid_tick <= 1 on the os_tick where os_cnt == OSR/2−1.
- en = 0:
  - cnt, os_cnt and acc hold.
  - All ticks 0 from the next edge.
  - Re-enabling resumes mid-interval.
- restart:
  - Clears cnt, os_cnt, acc and all ticks.
  - If cfg_pending, applies the shadow to active and clears cfg_pending.
  - First os_tick occurs L edges later.
- cfg_load:
  - Captures the inputs into the shadow and sets cfg_pending <= 1.
  - A later cfg_load before apply overwrites the shadow.
- Config apply happens on the cycle bit_tick is set, or on any cycle with en = 0 and cfg_pending:
  - active <= shadow, cfg_pending <= 0, acc <= 0.
  - os_cnt is already 0 at a bit boundary.
- Simultaneous events:
  - cfg_load in the same cycle as an apply boundary: the new value goes to the shadow and cfg_pending stays 1. The previous shadow (if pending) is applied; the new value applies at the following boundary.
  - cfg_load together with restart: the newly loaded values become active immediately and cfg_pending = 0.
- Changing osr_sel therefore never shortens or lengthens a bit in progress.
- rst mid-operation: everything returns to reset state on that edge and any pending config is lost.

Test Plan:
- Default config, en = 1 after reset → os_tick after edges 3, 6, 9…; bit_tick on the 16th os_tick (edge 48); mid_tick on the 8th (edge 24).
- cfg_load div_int = 3, div_frac = 8, osr_sel = 2 (loaded while en = 0, so applied immediately), then en = 1 → os_tick interval lengths 3, 4, 3, 4; bit_tick every 14 clks; mid_tick on the 2nd os_tick of each bit.
- Running at 16x, cfg_load osr_sel = 1 mid-bit → cfg_pending = 1 until the current bit_tick; the following bit is 8 os_ticks; no truncated bit.
- restart pulsed at os_cnt = 5, cnt = 1 → no ticks that cycle; next os_tick exactly div_int edges later; bit_tick after 16 further os_ticks.
- en held low for 10 cycles mid-interval → no ticks; after re-enable the interval completes with the remaining cycles only; div_int = 0 programmed → os_tick every cycle.
- rst asserted with cfg_pending = 1 → next edge: outputs 0, cfg_pending = 0, DEF config active.
